clkgen_frac_multi: RTL and testbench
====================================

Name: clkgen_frac_multi

Overview:
Parametrised successor to the fixed three-output PLL wrapper. It runs on one PLL output clock and derives NUM_CLOCKS independent fractional clock-enable streams through phase accumulators. Each increment is run-time reloadable. The block qualifies the PLL lock signal and releases per-channel resets in a staggered order. It sits between the board PLL and the MSX core and replaces hard-coded dividers (for example, 21.477 MHz enables derived from 85.909 MHz).

Parameters:
NUM_CLOCKS, 3, number of enable channels (1..8)
ACC_W, 32, phase accumulator and increment width
LOCK_STABLE, 1024, consecutive synchronised-locked cycles required before release (>=1)
RST_STAGGER, 16, cycles between successive channel reset releases (>=1)
INC_INIT, {NUM_CLOCKS{32'h4000_0000}}, packed reset value of the increment registers, channel 0 in the LSBs

Ports:
refclk  in  1  block clock (PLL output)
rst  in  1  asynchronous active-high reset
pll_locked  in  1  raw PLL lock, asynchronous to refclk
ch_enable  in  NUM_CLOCKS  per-channel run enable
inc_load  in  1  write strobe for an increment register
inc_sel  in  clog2(NUM_CLOCKS) (min 1)  target channel of the write
inc_data  in  ACC_W  new increment value
clk_en  out  NUM_CLOCKS  registered one-cycle enable pulses
ch_rst  out  NUM_CLOCKS  active-high per-channel reset for downstream logic
ready  out  1  high while every channel is released (RUN state)

Behaviour:
- Clock and reset: one clock, refclk. rst is asynchronous and active-high.
- Reset values: clk_en=0, ch_rst=all 1, ready=0, accumulators=0, increment registers=INC_INIT, FSM=WAIT_LOCK, counters=0.
- Lock synchroniser: pll_locked passes through a 2-flop synchroniser; lk_s is the second flop.
- FSM states: WAIT_LOCK, STABLE, RELEASE, RUN.
- WAIT_LOCK: moves to STABLE when lk_s=1, clearing the stable counter.
- STABLE: the counter increments each cycle lk_s=1. When it reaches LOCK_STABLE-1, move to RELEASE.
- RELEASE: ch_rst[0] falls on the first RELEASE edge. ch_rst[i] falls exactly RST_STAGGER cycles after ch_rst[i-1]. The FSM moves to RUN on the edge that clears the last channel's reset; ready=1 from that edge.
- Lock loss: lk_s=0 in STABLE, RELEASE or RUN means that on the next edge the FSM goes to WAIT_LOCK, ch_rst=all 1, ready=0, clk_en=0, all accumulators=0, counters=0. Increment registers are kept.
- Accumulator, channel i active (ch_rst[i]=0 and ch_enable[i]=1): {carry,acc} = acc + inc, an ACC_W+1-bit sum. acc takes the low ACC_W bits; clk_en[i] is registered from carry.
- Accumulator, channel i inactive: acc is held and clk_en[i]=0.
- Average enable rate = f_refclk * inc / 2^ACC_W.
- inc=0: the channel never pulses.
- inc=2^ACC_W-1: pulses every cycle after the first.
- Accumulator wrap-around is modular, with no saturation.
- inc_load: writes inc[inc_sel] on the edge. Carry in that same cycle uses the old value; the new value applies from the next cycle.
- inc_load with inc_sel >= NUM_CLOCKS: ignored.
- inc_load is accepted in every FSM state.
- Simultaneous lock loss and inc_load: the write occurs and the accumulators still clear.
- First-pulse timing: clk_en[i] first pulses no earlier than the 2nd cycle after release.
- ch_enable changes take effect on the next edge, with no phase reset.

Decomposition:
- Package clkgen_pkg: the FSM state enum (WAIT_LOCK/STABLE/RELEASE/RUN), a clog2-based width helper for inc_sel and counters, and the default-increment constant INC_DIV4 = 2^(ACC_W-2).
- Sub-module frac_acc_ch: one channel's accumulator, increment register and carry-to-clk_en register, instantiated NUM_CLOCKS times by generate.
- Top level: owns the synchroniser, FSM and stagger counter.

Test Plan:
1. Reset, then pll_locked=1, LOCK_STABLE=8, RST_STAGGER=4 -> ch_rst[0] falls 2+8 cycles after pll_locked rises (±1 for sync); ch_rst[1] falls 4 cycles later, ch_rst[2] 4 cycles after that; ready rises with ch_rst[2].
2. RUN, ACC_W=32, inc=0x4000_0000, ch_enable=1 -> clk_en[0] pulses exactly every 4th cycle; 400 cycles give 100 pulses.
3. inc=0x6666_6666 (0.4) for 1000 cycles -> exactly 400 pulses, gaps only 2 or 3 cycles. inc=0 -> 0 pulses.
4. pll_locked drops for 1 cycle mid-RELEASE -> within 3 edges: ch_rst=all 1, ready=0, clk_en=0, FSM back in WAIT_LOCK; full LOCK_STABLE requalification follows.
5. inc_load with inc_sel=1, inc_data=0x8000_0000 in RUN -> channel 1 switches to every-2nd-cycle pulses starting the cycle after the write; channels 0 and 2 are unchanged. inc_sel=3 with NUM_CLOCKS=3 -> no register changes.
6. ch_enable[2]=0 for 10 cycles, then 1 -> no pulses while low; the accumulator resumes from the held value (pulse phase continues, not restarted).

Source files
------------

// File: rtl/clkgen_pkg.sv
// Shared state type, width helper and default increment for the fractional
// clock-enable generator.
package clkgen_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } clk_state_e;

    // Divide-by-four increment for a 32-bit accumulator: 2^(32-2).
    localparam logic [31:0] INC_DIV4 = 32'h4000_0000;

    // Bits needed to hold the values 0..n-1, never less than one bit.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frac_acc_ch.sv
// One enable channel: run-time reloadable increment, phase accumulator and the
// registered carry that becomes the channel's clock-enable pulse.
module frac_acc_ch #(
    parameter int               ACC_W   = 32,
    parameter logic [ACC_W-1:0] INC_RST = '0
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             active,
    input  logic             clear,
    input  logic             load,
    input  logic [ACC_W-1:0] load_data,
    output logic             clk_en
);

    logic [ACC_W-1:0] inc_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, inc_q};

    // The increment survives lock loss; a write lands after this cycle's carry.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            inc_q <= INC_RST;
        end else if (load) begin
            inc_q <= load_data;
        end
    end

    // An inactive channel freezes its phase so re-enabling continues the pattern.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            clk_en <= 1'b0;
        end else if (clear) begin
            acc_q  <= '0;
            clk_en <= 1'b0;
        end else if (active) begin
            acc_q  <= sum[ACC_W-1:0];
            clk_en <= sum[ACC_W];
        end else begin
            clk_en <= 1'b0;
        end
    end

endmodule

// File: rtl/clkgen_frac_multi.sv
// PLL-lock qualification, staggered per-channel reset release and NUM_CLOCKS
// fractional clock-enable generators running on the PLL output clock.
module clkgen_frac_multi
    import clkgen_pkg::*;
#(
    parameter int                          NUM_CLOCKS  = 3,
    parameter int                          ACC_W       = 32,
    parameter int                          LOCK_STABLE = 1024,
    parameter int                          RST_STAGGER = 16,
    parameter logic [NUM_CLOCKS*ACC_W-1:0] INC_INIT    = {NUM_CLOCKS{INC_DIV4}},
    localparam int                         SEL_W       = width_of(NUM_CLOCKS)
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  pll_locked,
    input  logic [NUM_CLOCKS-1:0] ch_enable,
    input  logic                  inc_load,
    input  logic [SEL_W-1:0]      inc_sel,
    input  logic [ACC_W-1:0]      inc_data,
    output logic [NUM_CLOCKS-1:0] clk_en,
    output logic [NUM_CLOCKS-1:0] ch_rst,
    output logic                  ready
);

    localparam int               STB_W    = width_of(LOCK_STABLE);
    localparam int               STG_W    = width_of(RST_STAGGER);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(RST_STAGGER - 1);
    localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(NUM_CLOCKS - 1);

    logic                  lk_m;
    logic                  lk_s;
    clk_state_e            state_q, state_d;
    logic [STB_W-1:0]      stb_cnt_q, stb_cnt_d;
    logic [STG_W-1:0]      stg_cnt_q, stg_cnt_d;
    logic [SEL_W-1:0]      rel_idx_q, rel_idx_d;
    logic [NUM_CLOCKS-1:0] ch_rst_q, ch_rst_d;
    logic                  lock_lost;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lk_m <= 1'b0;
            lk_s <= 1'b0;
        end else begin
            lk_m <= pll_locked;
            lk_s <= lk_m;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= WAIT_LOCK;
            stb_cnt_q <= '0;
            stg_cnt_q <= '0;
            rel_idx_q <= '0;
            ch_rst_q  <= '1;
        end else begin
            state_q   <= state_d;
            stb_cnt_q <= stb_cnt_d;
            stg_cnt_q <= stg_cnt_d;
            rel_idx_q <= rel_idx_d;
            ch_rst_q  <= ch_rst_d;
        end
    end

    // rel_idx tracks the most recently released channel during RELEASE.
    always_comb begin
        state_d   = state_q;
        stb_cnt_d = stb_cnt_q;
        stg_cnt_d = stg_cnt_q;
        rel_idx_d = rel_idx_q;
        ch_rst_d  = ch_rst_q;
        lock_lost = 1'b0;

        if (state_q != WAIT_LOCK && !lk_s) begin
            lock_lost = 1'b1;
            state_d   = WAIT_LOCK;
            stb_cnt_d = '0;
            stg_cnt_d = '0;
            rel_idx_d = '0;
            ch_rst_d  = '1;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (lk_s) begin
                        state_d   = STABLE;
                        stb_cnt_d = '0;
                    end
                end
                STABLE: begin
                    if (stb_cnt_q == STB_LAST) begin
                        ch_rst_d[0] = 1'b0;
                        stg_cnt_d   = '0;
                        rel_idx_d   = '0;
                        state_d     = (NUM_CLOCKS == 1) ? RUN : RELEASE;
                    end else begin
                        stb_cnt_d = stb_cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (stg_cnt_q == STG_LAST) begin
                        stg_cnt_d           = '0;
                        rel_idx_d           = rel_idx_q + 1'b1;
                        ch_rst_d[rel_idx_d] = 1'b0;
                        if (rel_idx_d == CH_LAST) begin
                            state_d = RUN;
                        end
                    end else begin
                        stg_cnt_d = stg_cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = WAIT_LOCK;
                end
            endcase
        end
    end

    assign ch_rst = ch_rst_q;
    assign ready  = (state_q == RUN);

    for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_ch
        frac_acc_ch #(
            .ACC_W   (ACC_W),
            .INC_RST (INC_INIT[g*ACC_W +: ACC_W])
        ) u_ch (
            .refclk    (refclk),
            .rst       (rst),
            .active    (!ch_rst_q[g] && ch_enable[g]),
            .clear     (lock_lost),
            .load      (inc_load && (inc_sel == SEL_W'(g))),
            .load_data (inc_data),
            .clk_en    (clk_en[g])
        );
    end

endmodule

// File: tb/tb_clkgen_frac_multi.sv
// Bench for clkgen_frac_multi: rate table, directed lock/reload/enable sequences and
// a randomized run, all compared every cycle against a lock-history reference model.
module tb_clkgen_frac_multi;

    localparam int                NCH         = 3;
    localparam int                LS          = 8;
    localparam int                RS          = 4;
    localparam logic [31:0]       INC_RST_VAL = 32'h4000_0000;
    localparam longint unsigned   WRAP        = 64'h1_0000_0000;

    logic            refclk     = 1'b0;
    logic            rst        = 1'b1;
    logic            pll_locked = 1'b0;
    logic [NCH-1:0]  ch_enable  = '0;
    logic            inc_load   = 1'b0;
    logic [1:0]      inc_sel    = '0;
    logic [31:0]     inc_data   = '0;
    logic [NCH-1:0]  clk_en;
    logic [NCH-1:0]  ch_rst;
    logic            ready;

    int    vec_cnt = 0;
    int    err_cnt = 0;
    string phase   = "init";

    // Reference model: m_n counts consecutive edges that saw a qualified lock.
    longint unsigned m_acc [NCH];
    logic [31:0]     m_inc [NCH];
    logic [NCH-1:0]  m_en;
    int              m_n;
    logic            m_h1, m_h2;

    typedef struct {
        logic [31:0] inc;
        int          cycles;
        int          exp_pulses;
        int          gap_lo;
        int          gap_hi;
    } rate_vec_t;

    rate_vec_t tv [5];

    clkgen_frac_multi #(
        .NUM_CLOCKS  (NCH),
        .ACC_W       (32),
        .LOCK_STABLE (LS),
        .RST_STAGGER (RS)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .ch_enable  (ch_enable),
        .inc_load   (inc_load),
        .inc_sel    (inc_sel),
        .inc_data   (inc_data),
        .clk_en     (clk_en),
        .ch_rst     (ch_rst),
        .ready      (ready)
    );

    always #5 refclk = ~refclk;

    function automatic logic [NCH-1:0] m_rst_vec();
        logic [NCH-1:0] r;
        for (int i = 0; i < NCH; i++) r[i] = (m_n < LS + 1 + i * RS);
        return r;
    endfunction

    function automatic logic m_ready();
        return (m_n >= LS + 1 + (NCH - 1) * RS);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_acc[i] = 0;
            m_inc[i] = INC_RST_VAL;
        end
        m_en = '0;
        m_n  = 0;
        m_h1 = 1'b0;
        m_h2 = 1'b0;
    endfunction

    function automatic void model_edge();
        logic            lk;
        logic [NCH-1:0]  rel;
        longint unsigned s;
        if (rst) begin
            model_reset();
            return;
        end
        lk   = m_h2;
        m_h2 = m_h1;
        m_h1 = pll_locked;
        rel  = ~m_rst_vec();
        if (!lk) begin
            m_n  = 0;
            m_en = '0;
            for (int i = 0; i < NCH; i++) m_acc[i] = 0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (rel[i] && ch_enable[i]) begin
                    s        = m_acc[i] + 64'(m_inc[i]);
                    m_en[i]  = (s >= WRAP);
                    m_acc[i] = s % WRAP;
                end else begin
                    m_en[i] = 1'b0;
                end
            end
            if (m_n < 100000) m_n++;
        end
        if (inc_load && int'(inc_sel) < NCH) m_inc[inc_sel] = inc_data;
    endfunction

    task automatic checkOutput();
        logic [2*NCH:0] exp_v;
        logic [2*NCH:0] act_v;
        exp_v = {m_en, m_rst_vec(), m_ready()};
        act_v = {clk_en, ch_rst, ready};
        vec_cnt++;
        if (act_v !== exp_v) begin
            err_cnt++;
            $display("[TB] FAIL %s {clk_en,ch_rst,ready}: got %b expected %b at %0t",
                     phase, act_v, exp_v, $time);
        end
    endtask

    task automatic check_val(input string name, input longint act, input longint exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("[TB] FAIL %s %s: got %0d expected %0d", phase, name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        vec_cnt++;
        if (act < lo || act > hi) begin
            err_cnt++;
            $display("[TB] FAIL %s %s: got %0d expected %0d..%0d", phase, name, act, lo, hi);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        model_edge();
        #1;
        checkOutput();
    endtask

    task automatic applyStimulus(input logic pll, input logic [NCH-1:0] en, input logic load,
                                 input logic [1:0] sel, input logic [31:0] data);
        pll_locked = pll;
        ch_enable  = en;
        inc_load   = load;
        inc_sel    = sel;
        inc_data   = data;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 2'd0, 32'd0);
        tick();
        check_val("reset_state", longint'({clk_en, ch_rst, ready}), longint'(7'b000_111_0));
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_rst_fall(input int ch, input int bound, output int cycles);
        cycles = 0;
        while (ch_rst[ch] && cycles < bound) begin
            tick();
            cycles++;
        end
        check_val($sformatf("ch_rst%0d_fall_timeout", ch), longint'(ch_rst[ch]), 0);
    endtask

    task automatic count_pulses(input int cycles, input int ch, output int pulses,
                                output int gmin, output int gmax);
        int last;
        last   = -1;
        pulses = 0;
        gmin   = 1 << 30;
        gmax   = 0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            if (clk_en[ch]) begin
                pulses++;
                if (last >= 0) begin
                    if (k - last < gmin) gmin = k - last;
                    if (k - last > gmax) gmax = k - last;
                end
                last = k;
            end
        end
    endtask

    initial begin
        int c, p, gmin, gmax;
        logic seen;

        // Counts are over the window after the first active edge (acc already = inc).
        tv[0] = '{32'h4000_0000,  400, 100, 4, 4};
        tv[1] = '{32'h6666_6666, 1000, 400, 2, 3};
        tv[2] = '{32'h0000_0000,  200,   0, 0, 0};
        tv[3] = '{32'h8000_0000,  100,  50, 2, 2};
        tv[4] = '{32'hFFFF_FFFF,   50,  50, 1, 1};

        model_reset();

        phase = "release_timing";
        do_reset();
        applyStimulus(1'b1, '1, 1'b0, 2'd0, 32'd0);
        wait_rst_fall(0, 100, c);
        check_range("ch_rst0_delay", c, LS + 1, LS + 3);
        check_val("ready_early", longint'(ready), 0);
        wait_rst_fall(1, 100, c);
        check_val("ch_rst1_stagger", c, RS);
        check_val("ready_mid", longint'(ready), 0);
        wait_rst_fall(2, 100, c);
        check_val("ch_rst2_stagger", c, RS);
        check_val("ready_with_last", longint'(ready), 1);

        for (int i = 0; i < 5; i++) begin
            phase = $sformatf("rate_%08h", tv[i].inc);
            do_reset();
            applyStimulus(1'b1, '1, 1'b1, 2'd0, tv[i].inc);
            tick();
            inc_load = 1'b0;
            wait_rst_fall(0, 100, c);
            tick();
            check_val("first_edge_no_pulse", longint'(clk_en[0]), 0);
            count_pulses(tv[i].cycles, 0, p, gmin, gmax);
            check_val("pulse_count", p, tv[i].exp_pulses);
            if (tv[i].exp_pulses > 1) begin
                check_range("gap_min", gmin, tv[i].gap_lo, tv[i].gap_hi);
                check_range("gap_max", gmax, tv[i].gap_lo, tv[i].gap_hi);
            end
        end

        phase = "lock_drop";
        do_reset();
        applyStimulus(1'b1, '1, 1'b0, 2'd0, 32'd0);
        wait_rst_fall(0, 100, c);
        tick();
        tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (ch_rst == '1 && !ready && clk_en == '0) seen = 1'b1;
        end
        check_val("cleared_within_3", longint'(seen), 1);
        wait_rst_fall(0, 100, c);
        check_range("requalify_delay", c, LS - 1, LS + 1);

        phase = "inc_reload";
        c = 0;
        while (!ready && c < 100) begin
            tick();
            c++;
        end
        check_val("ready_timeout", longint'(ready), 1);
        for (int k = 0; k < 5; k++) tick();
        applyStimulus(1'b1, '1, 1'b1, 2'd1, 32'h8000_0000);
        tick();
        inc_load = 1'b0;
        count_pulses(20, 1, p, gmin, gmax);
        check_val("ch1_half_rate", p, 10);
        check_val("ch1_gap", gmax, 2);
        count_pulses(20, 0, p, gmin, gmax);
        check_val("ch0_unchanged", p, 5);
        applyStimulus(1'b1, '1, 1'b1, 2'd3, 32'h0000_0000);
        tick();
        inc_load = 1'b0;
        count_pulses(20, 0, p, gmin, gmax);
        check_val("sel3_ch0", p, 5);
        count_pulses(20, 1, p, gmin, gmax);
        check_val("sel3_ch1", p, 10);
        count_pulses(20, 2, p, gmin, gmax);
        check_val("sel3_ch2", p, 5);

        phase = "ch_enable_hold";
        ch_enable = 3'b011;
        count_pulses(10, 2, p, gmin, gmax);
        check_val("ch2_disabled_pulses", p, 0);
        ch_enable = 3'b111;
        count_pulses(20, 2, p, gmin, gmax);
        check_val("ch2_resumed_pulses", p, 5);

        phase = "random";
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] d;
            case ($urandom_range(0, 3))
                0:       d = 32'h0000_0000;
                1:       d = 32'hFFFF_FFFF;
                2:       d = 32'h8000_0000;
                default: d = $urandom;
            endcase
            applyStimulus($urandom_range(0, 149) != 0,
                          ($urandom_range(0, 15) == 0) ? NCH'($urandom) : ch_enable,
                          $urandom_range(0, 7) == 0,
                          2'($urandom_range(0, 3)),
                          d);
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
